// File: rtl/hazard_control.sv
// hazard_control: pipeline hazard sequencer for the 5-stage integer pipeline.
// Decides front-end stalls, ID/EX bubbles and IF/ID flushes for load-use
// hazards, taken branches resolved in EX and multi-cycle mul/div ops
// (start/done handshake). Also keeps a saturating stall counter and a
// sticky watchdog error for a hung mul/div unit.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_id_rs1/2, i_id_use_rs1/2   ID source registers and their use flags
//   i_id_muldiv                  ID instruction is a mul/div op
//   i_ex_memread, i_ex_rd        EX instruction is a load, its destination
//   i_ex_branch_taken            EX branch/jump resolved taken
//   i_md_done                    mul/div result ready pulse
//   o_pc_write, o_ifid_write     front-end advance enables (combinational)
//   o_ifid_flush, o_idex_bubble  NOP insertion controls (combinational)
//   o_md_start                   mul/div start pulse (combinational)
//   o_stall_cnt                  saturating count of pc_write=0 cycles
//   o_md_error                   sticky watchdog expiry
//   o_state                      0=RUN, 1=MD_WAIT
module hazard_control #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_id_muldiv,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_branch_taken,
  input  logic             i_md_done,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_md_start,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic             o_md_error,
  output logic             o_state
);

  // Wait counter only needs to reach MD_TIMEOUT-1.
  localparam int unsigned WAIT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);
  localparam bit WD_EN = (MD_TIMEOUT != 0);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_md_wait_cnt;
  logic [WAIT_W-1:0]   w_md_wait_cnt_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic                r_md_error;
  logic                w_md_error_set;
  logic                w_load_use;
  logic                w_pc_write;
  logic                w_ifid_write;
  logic                w_ifid_flush;
  logic                w_idex_bubble;
  logic                w_md_start;

  // Load in EX feeding a register that ID actually reads (x0 never hazards).
  assign w_load_use = i_ex_memread & (i_ex_rd != 5'd0) &
                      ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                       (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

  // Next-state and same-cycle control decisions.
  always_comb begin
    w_state_nxt       = r_state;
    w_md_wait_cnt_nxt = r_md_wait_cnt;
    w_md_error_set    = 1'b0;
    w_pc_write        = 1'b1;
    w_ifid_write      = 1'b1;
    w_ifid_flush      = 1'b0;
    w_idex_bubble     = 1'b0;
    w_md_start        = 1'b0;
    if (i_rst) begin
      // Hold the front end and fill the pipe with NOPs while in reset.
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_state_nxt   = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (i_ex_branch_taken) begin
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
          end else if (w_load_use) begin
            // A pending mul/div is not started; it re-evaluates next cycle.
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
          end else if (i_id_muldiv) begin
            w_md_start        = 1'b1;
            w_pc_write        = 1'b0;
            w_ifid_write      = 1'b0;
            w_idex_bubble     = 1'b1;
            w_md_wait_cnt_nxt = '0;
            w_state_nxt       = MD_WAIT;
          end
        end
        MD_WAIT: begin
          if (i_md_done) begin
            w_state_nxt = RUN;
          end else if (WD_EN && (r_md_wait_cnt == WAIT_LAST)) begin
            // Hung unit: release the instruction and flag it.
            w_md_error_set = 1'b1;
            w_state_nxt    = RUN;
          end else begin
            w_pc_write        = 1'b0;
            w_ifid_write      = 1'b0;
            w_idex_bubble     = 1'b1;
            w_md_wait_cnt_nxt = r_md_wait_cnt + WAIT_W'(1);
          end
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= RUN;
      r_md_wait_cnt <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_md_wait_cnt <= w_md_wait_cnt_nxt;
    end
  end

  // Saturating stall statistics and sticky watchdog error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_md_error  <= 1'b0;
    end else begin
      if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_md_error_set) begin
        r_md_error <= 1'b1;
      end
    end
  end

  assign o_pc_write    = w_pc_write;
  assign o_ifid_write  = w_ifid_write;
  assign o_ifid_flush  = w_ifid_flush;
  assign o_idex_bubble = w_idex_bubble;
  assign o_md_start    = w_md_start;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_md_error    = r_md_error;
  assign o_state       = 1'(r_state);

endmodule

// File: tb/tb_hazard_control.sv
// Directed testbench for hazard_control. Instance A (CNT_W=16, MD_TIMEOUT=8)
// covers the main functions and the watchdog; instance B (CNT_W=4, no
// watchdog) shares the inputs and covers saturation and reset mid-MD_WAIT.
module tb_hazard_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, id_muldiv, ex_memread, ex_branch_taken, md_done;

  logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_md_start, a_md_error, a_state;
  logic [15:0] a_stall_cnt;
  logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_md_start, b_md_error, b_state;
  logic [3:0]  b_stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  // Control bundle {pc_write, ifid_write, ifid_flush, idex_bubble, md_start}.
  localparam logic [4:0] C_DEF  = 5'b11000;
  localparam logic [4:0] C_LU   = 5'b00010;
  localparam logic [4:0] C_BR   = 5'b11110;
  localparam logic [4:0] C_MDS  = 5'b00011;
  localparam logic [4:0] C_WAIT = 5'b00010;
  localparam logic [4:0] C_RST  = 5'b00110;

  wire [4:0] a_ctrl = {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_md_start};
  wire [4:0] b_ctrl = {b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_md_start};

  always #5 clk = ~clk;

  hazard_control #(.CNT_W(16), .MD_TIMEOUT(8)) u_a (
    .i_clk(clk), .i_rst(rst),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_id_muldiv(id_muldiv), .i_ex_memread(ex_memread), .i_ex_rd(ex_rd),
    .i_ex_branch_taken(ex_branch_taken), .i_md_done(md_done),
    .o_pc_write(a_pc_write), .o_ifid_write(a_ifid_write),
    .o_ifid_flush(a_ifid_flush), .o_idex_bubble(a_idex_bubble),
    .o_md_start(a_md_start), .o_stall_cnt(a_stall_cnt),
    .o_md_error(a_md_error), .o_state(a_state)
  );

  hazard_control #(.CNT_W(4), .MD_TIMEOUT(0)) u_b (
    .i_clk(clk), .i_rst(rst),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_id_muldiv(id_muldiv), .i_ex_memread(ex_memread), .i_ex_rd(ex_rd),
    .i_ex_branch_taken(ex_branch_taken), .i_md_done(md_done),
    .o_pc_write(b_pc_write), .o_ifid_write(b_ifid_write),
    .o_ifid_flush(b_ifid_flush), .o_idex_bubble(b_idex_bubble),
    .o_md_start(b_md_start), .o_stall_cnt(b_stall_cnt),
    .o_md_error(b_md_error), .o_state(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle mid-cycle.
  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_muldiv = 1'b0;
    ex_memread = 1'b0; ex_branch_taken = 1'b0; md_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Reset
    tick();
    settle();
    chk("rst_ctrl", 32'(a_ctrl), 32'(C_RST));
    chk("rst_stall", 32'(a_stall_cnt), 32'd0);
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_err", 32'(a_md_error), 32'd0);
    tick();
    settle();
    chk("rst_hold_stall", 32'(a_stall_cnt), 32'd0);
    rst = 1'b0;
    settle();
    chk("idle_ctrl", 32'(a_ctrl), 32'(C_DEF));
    tick();
    chk("idle_stall", 32'(a_stall_cnt), 32'd0);

    // Load-use on rs2
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    settle();
    chk("lu_rs2_ctrl", 32'(a_ctrl), 32'(C_LU));
    tick();
    exp_stall = 1;
    chk("lu_rs2_stall", 32'(a_stall_cnt), 32'(exp_stall));
    // Same with x0 as destination: no hazard
    ex_rd = 5'd0; id_rs2 = 5'd0;
    settle();
    chk("lu_x0_ctrl", 32'(a_ctrl), 32'(C_DEF));
    tick();
    chk("lu_x0_stall", 32'(a_stall_cnt), 32'(exp_stall));
    // rs1 match, not used -> no stall; used -> stall
    clear_inputs();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
    settle();
    chk("lu_rs1_unused", 32'(a_ctrl), 32'(C_DEF));
    id_use_rs1 = 1'b1;
    settle();
    chk("lu_rs1_used", 32'(a_ctrl), 32'(C_LU));
    tick();
    exp_stall = 2;
    chk("lu_rs1_stall", 32'(a_stall_cnt), 32'(exp_stall));

    // Branch beats load-use and mul/div
    ex_branch_taken = 1'b1; id_muldiv = 1'b1;
    settle();
    chk("br_ctrl", 32'(a_ctrl), 32'(C_BR));
    tick();
    chk("br_state", 32'(a_state), 32'd0);
    chk("br_stall", 32'(a_stall_cnt), 32'(exp_stall));
    clear_inputs();

    // md_done while in RUN is ignored
    md_done = 1'b1;
    settle();
    chk("run_done_ctrl", 32'(a_ctrl), 32'(C_DEF));
    tick();
    chk("run_done_state", 32'(a_state), 32'd0);
    md_done = 1'b0;

    // Mul/div handshake, md_done at T+4
    id_muldiv = 1'b1;
    settle();
    chk("md_T_ctrl", 32'(a_ctrl), 32'(C_MDS));
    tick();
    chk("md_T1_state", 32'(a_state), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      settle();
      chk($sformatf("md_wait_%0d", k), 32'(a_ctrl), 32'(C_WAIT));
      tick();
    end
    md_done = 1'b1;
    settle();
    chk("md_release", 32'(a_ctrl), 32'(C_DEF));
    tick();
    exp_stall = exp_stall + 4;
    md_done = 1'b0; id_muldiv = 1'b0;
    chk("md_back_run", 32'(a_state), 32'd0);
    chk("md_stall", 32'(a_stall_cnt), 32'(exp_stall));

    // Load-use and mul/div together: start deferred one cycle
    ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1; id_muldiv = 1'b1;
    settle();
    chk("lumd_T", 32'(a_ctrl), 32'(C_LU));
    tick();
    ex_memread = 1'b0; ex_rd = 5'd0;
    settle();
    chk("lumd_T1", 32'(a_ctrl), 32'(C_MDS));
    tick();
    chk("lumd_state", 32'(a_state), 32'd1);
    md_done = 1'b1;
    settle();
    chk("lumd_release", 32'(a_ctrl), 32'(C_DEF));
    tick();
    clear_inputs();
    exp_stall = exp_stall + 2;
    chk("lumd_stall", 32'(a_stall_cnt), 32'(exp_stall));

    // Watchdog on A: md_done never arrives
    id_muldiv = 1'b1;
    settle();
    chk("wd_start", 32'(a_ctrl), 32'(C_MDS));
    tick();
    for (int k = 1; k <= 7; k++) begin
      settle();
      chk($sformatf("wd_wait_%0d", k), 32'(a_ctrl), 32'(C_WAIT));
      chk($sformatf("wd_noerr_%0d", k), 32'(a_md_error), 32'd0);
      tick();
    end
    settle();
    chk("wd_release", 32'(a_ctrl), 32'(C_DEF));
    chk("wd_err_not_yet", 32'(a_md_error), 32'd0);
    tick();
    id_muldiv = 1'b0;
    exp_stall = exp_stall + 8;
    settle();
    chk("wd_err_set", 32'(a_md_error), 32'd1);
    chk("wd_state", 32'(a_state), 32'd0);
    chk("wd_stall", 32'(a_stall_cnt), 32'(exp_stall));
    tick();
    tick();
    chk("wd_sticky", 32'(a_md_error), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("wd_rst_err", 32'(a_md_error), 32'd0);
    chk("wd_rst_stall", 32'(a_stall_cnt), 32'd0);
    chk("b_rst_state", 32'(b_state), 32'd0);

    // Saturation on B (4-bit counter, no watchdog)
    id_muldiv = 1'b1;
    tick();
    id_muldiv = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      settle();
      chk($sformatf("sat_%0d", n), 32'(b_stall_cnt), (n > 15) ? 32'd15 : 32'(n));
      tick();
    end
    chk("sat_final", 32'(b_stall_cnt), 32'd15);
    chk("sat_state", 32'(b_state), 32'd1);

    // Reset in MD_WAIT abandons the handshake
    rst = 1'b1;
    settle();
    chk("mdrst_ctrl", 32'(b_ctrl), 32'(C_RST));
    tick();
    chk("mdrst_state", 32'(b_state), 32'd0);
    chk("mdrst_stall", 32'(b_stall_cnt), 32'd0);
    settle();
    chk("mdrst_ctrl2", 32'(b_ctrl), 32'(C_RST));
    tick();
    chk("mdrst_nocount", 32'(b_stall_cnt), 32'd0);
    rst = 1'b0;
    md_done = 1'b1;
    settle();
    chk("stray_done_ctrl", 32'(b_ctrl), 32'(C_DEF));
    tick();
    md_done = 1'b0;
    chk("stray_done_state", 32'(b_state), 32'd0);
    chk("stray_done_stall", 32'(b_stall_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline hazard sequencer for the 5-stage integer pipeline. It sits beside the forwarding unit in ID/EX and decides when the front end stalls, when bubbles are inserted and when IF/ID is flushed. It covers three cases: load-use hazards that forwarding cannot hide, taken branches resolved in EX, and instructions that must wait on the multi-cycle mul/div unit through a start/done handshake. It also keeps stall statistics and detects a hung mul/div unit.

## Interface
- CNT_W, 16, width of the saturating stall-cycle counter
- MD_TIMEOUT, 64, maximum MD_WAIT cycles before md_error; 0 disables the watchdog
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- id_rs1, id_rs2  input  5  source register indices of the instruction in ID
- id_use_rs1, id_use_rs2  input  1  ID instruction actually reads rs1 / rs2
- id_muldiv  input  1  ID instruction is a multi-cycle mul/div op
- ex_memread  input  1  instruction in EX is a load
- ex_rd  input  5  destination register of the EX instruction
- ex_branch_taken  input  1  branch/jump in EX resolved taken this cycle
- md_done  input  1  mul/div unit result ready (single-cycle pulse)
- pc_write  output  1  PC may update
- ifid_write  output  1  IF/ID register may load
- ifid_flush  output  1  IF/ID loads a NOP
- idex_bubble  output  1  ID/EX loads a NOP (control zeroed)
- md_start  output  1  one-cycle start pulse to the mul/div unit
- stall_cnt  output  CNT_W  total cycles with pc_write=0 since reset, saturating
- md_error  output  1  sticky: watchdog expired; cleared only by rst
- state  output  1  0=RUN, 1=MD_WAIT (debug)

## Operation
- Registered: state, stall_cnt, md_wait_cnt (internal, wide enough for MD_TIMEOUT), md_error. All other outputs are combinational from state and inputs.
- Default outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, md_start=0.
- load_use = ex_memread & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN, priority order:
  - 1. ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1; stay RUN. load_use and id_muldiv are ignored this cycle.
  - 2. load_use: pc_write=0, ifid_write=0, idex_bubble=1; stay RUN. md_start is withheld even if id_muldiv=1; the op re-evaluates next cycle.
  - 3. id_muldiv: md_start=1, pc_write=0, ifid_write=0, idex_bubble=1; md_wait_cnt<=0; go MD_WAIT.
  - 4. Otherwise: defaults.
- MD_WAIT:
  - md_done=1: defaults, so the mul/div instruction advances to EX; go RUN.
  - Otherwise: pc_write=0, ifid_write=0, idex_bubble=1; md_wait_cnt++.
  - MD_TIMEOUT!=0 and md_wait_cnt==MD_TIMEOUT-1 without md_done: set md_error=1, apply defaults (instruction released), go RUN.
  - ex_branch_taken cannot occur here, because EX holds bubbles; it is ignored if asserted.
  - md_start is never asserted in MD_WAIT.
- stall_cnt increments every non-reset cycle with pc_write=0. It holds at 2^CNT_W-1.
- md_done sampled in RUN is ignored.

## Timing
- Reset (rst=1 at a clock edge): state<=RUN, stall_cnt<=0, md_wait_cnt<=0, md_error<=0.
- While rst=1, outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, md_start=0, and stall_cnt does not count.
- Reset mid-MD_WAIT abandons the handshake; any later stray md_done in RUN is ignored.
- Decisions are same-cycle, with zero latency from inputs to control outputs.
- Load-use costs exactly 1 bubble. Branch costs 2 slots (IF/ID flushed plus ID/EX bubble).
- Mul/div: md_start in cycle T, first possible md_done in T+1. The pipeline resumes in the cycle md_done is high. Stall cycles = 1 + number of MD_WAIT cycles before md_done.
- Watchdog release occurs in cycle T+MD_TIMEOUT with md_error high from the next cycle.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt 0->1. Same stimulus with ex_rd=0 -> no stall.
- Branch beats hazards: ex_branch_taken=1 together with load_use=1 and id_muldiv=1 -> ifid_flush=1, idex_bubble=1, pc_write=1, md_start=0, state stays RUN.
- Mul/div handshake: id_muldiv=1 at T -> md_start=1 at T only; md_done at T+4 -> stalls at T..T+3, release at T+4, stall_cnt=4, state back to RUN.
- Load-use then mul/div: cycle T has load_use=1 and id_muldiv=1 -> no md_start at T; md_start at T+1.
- Watchdog with MD_TIMEOUT=8 and md_done never asserted -> release at T+8, md_error=1 from T+9 and sticky. Then rst for one cycle -> md_error=0, stall_cnt=0.
- Saturation and reset mid-op: with CNT_W=4, hold a mul/div stall for 20 cycles -> stall_cnt stays at 15. Assert rst during MD_WAIT -> state=RUN and reset output values hold during rst. A later md_done in RUN is ignored.
